// File: rtl/pwm_duty_meter.sv
// ---------------------------------------------------------------------------
// pwm_duty_meter
//
// Measures an incoming PWM waveform and reports its period (rise to rise) and
// high time (rise to fall) in clk cycles. Acts as the receive end of the LED
// PWM generator for loop-back checking, and as a reader for external PWM
// sources. If no rising edge arrives within TIMEOUT cycles the block reports a
// static (stuck) input together with the level it is stuck at.
//
// Parameters
//   CNT_W    width of all cycle counters and measurement outputs
//   TIMEOUT  cycles without a rising edge before a static result
//            (2 <= TIMEOUT <= 2^CNT_W-1)
//
// Ports
//   clk         in   1      system clock, only clock domain
//   rst_n       in   1      asynchronous active-low reset
//   pwm_in      in   1      asynchronous PWM input
//   period_o    out  CNT_W  last measured period in clk cycles (0 on static)
//   high_o      out  CNT_W  last measured high time in clk cycles (0 on static)
//   static_o    out  1      1 = last result was a timeout
//   level_o     out  1      synchronized input level captured at the timeout
//   meas_vld_o  out  1      one-cycle pulse when the result outputs update
// ---------------------------------------------------------------------------
module pwm_duty_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             static_o,
    output logic             level_o,
    output logic             meas_vld_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Input synchronizer: s1/s2 form the 2-FF synchronizer, s3 holds the
    // previous synchronized sample for edge decoding.
    logic s1_reg, s2_reg, s3_reg;
    logic rise, fall;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
    logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [CNT_W-1:0] hi_lat_reg, hi_lat_next;
    logic             do_meas, do_static;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= pwm_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise = s2_reg & ~s3_reg;
    assign fall = ~s2_reg & s3_reg;

    // Next-state and event decode.
    always_comb begin
        // The period counter restarts at 1 in the rise cycle so that the value
        // seen at the next rise equals the rise-to-rise distance exactly.
        if (rise) begin
            per_cnt_next = CNT_ONE;
        end else if (per_cnt_reg == CNT_MAX) begin
            per_cnt_next = per_cnt_reg;
        end else begin
            per_cnt_next = per_cnt_reg + CNT_ONE;
        end

        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        hi_lat_next   = hi_lat_reg;
        do_meas       = 1'b0;
        do_static     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // First partial period after IDLE is discarded.
                if (rise) begin
                    state_next = ST_HIGH;
                end else if (fall) begin
                    idle_cnt_next = CNT_ONE;
                end else if (idle_cnt_reg == TIMEOUT_C) begin
                    do_static     = 1'b1;
                    idle_cnt_next = CNT_ONE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + CNT_ONE;
                end
            end
            ST_HIGH: begin
                // A rise cannot occur here (a fall always comes first), so the
                // timeout is checked ahead of the fall: a high time that reaches
                // TIMEOUT would otherwise leave LOW past its timeout point.
                if (per_cnt_reg == TIMEOUT_C) begin
                    do_static     = 1'b1;
                    idle_cnt_next = CNT_ONE;
                    state_next    = ST_IDLE;
                end else if (fall) begin
                    hi_lat_next = per_cnt_reg;
                    state_next  = ST_LOW;
                end
            end
            ST_LOW: begin
                // Rise takes priority over a coincident timeout.
                if (rise) begin
                    do_meas    = 1'b1;
                    state_next = ST_HIGH;
                end else if (per_cnt_reg == TIMEOUT_C) begin
                    do_static     = 1'b1;
                    idle_cnt_next = CNT_ONE;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            per_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
            hi_lat_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            per_cnt_reg  <= per_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
            hi_lat_reg   <= hi_lat_next;
        end
    end

    // Result registers hold between updates; level_o changes only on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_o   <= '0;
            high_o     <= '0;
            static_o   <= 1'b0;
            level_o    <= 1'b0;
            meas_vld_o <= 1'b0;
        end else begin
            meas_vld_o <= do_meas | do_static;
            if (do_meas) begin
                period_o <= per_cnt_reg;
                high_o   <= hi_lat_reg;
                static_o <= 1'b0;
            end else if (do_static) begin
                period_o <= '0;
                high_o   <= '0;
                static_o <= 1'b1;
                level_o  <= s2_reg;
            end
        end
    end

endmodule
